// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures bytes from a UART receiver into a FIFO and hands them to a ready/valid consumer.
// Ports:
//   clk_50m     in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   enable      in   1 = capture bytes from the receiver
//   rx_rdy      in   receiver byte-ready flag, held until cleared
//   rx_data     in   receiver byte, valid while rx_rdy is high
//   rx_rdy_clr  out  one-cycle clear pulse back to the receiver
//   m_data      out  FIFO head byte, 8'h00 when empty
//   m_valid     out  FIFO non-empty
//   m_ready     in   consumer takes the head byte when m_valid is high
//   flush       in   synchronous FIFO discard
//   fifo_count  out  occupancy, 0..DEPTH
//   overrun     out  sticky: a byte was dropped because the FIFO was full
//   overrun_clr in   clears overrun and drop_count
//   drop_count  out  dropped-byte count, saturating at 8'hFF
module uart_rx_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rx_rdy,
    input  logic [7:0]               rx_data,
    output logic                     rx_rdy_clr,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_HOLD} state_t;

    state_t state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic capture, pop, full, push, drop;

    always_comb begin
        capture = (state == S_IDLE) && enable && rx_rdy;
        state_nx = state == S_CLEAR ? S_HOLD :
                   state == S_HOLD  ? S_IDLE :
                   capture          ? S_CLEAR : S_IDLE;
    end

    assign full    = fifo_count == CNT_FULL;
    assign pop     = m_valid && m_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push    = capture && (!full || pop) && !flush;
    // Bytes captured during a flush are discarded, never counted as drops.
    assign drop    = capture && full && !pop && !flush;
    assign m_valid = fifo_count != '0;
    assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_rdy_clr <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            state      <= state_nx;
            rx_rdy_clr <= state_nx == S_CLEAR;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop) fifo_count <= fifo_count + CNT_ONE;
                else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
            end
            // A drop in the same cycle as a clear wins: the new drop is the first one counted.
            overrun    <= drop || (overrun && !overrun_clr);
            drop_count <= drop ? (overrun_clr ? 8'd1 : drop_count == 8'hFF ? 8'hFF : drop_count + 8'd1) :
                          overrun_clr ? 8'd0 : drop_count;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (push) mem[wr_ptr] <= rx_data;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl with a byte scoreboard.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 8;

    logic clk_50m, rst_n, enable, rx_rdy, rx_rdy_clr, m_valid, m_ready, flush, overrun, overrun_clr;
    logic [7:0] rx_data, m_data, drop_count;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0] sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int clr_seen;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .enable(enable), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_rdy_clr(rx_rdy_clr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .fifo_count(fifo_count), .overrun(overrun), .overrun_clr(overrun_clr),
        .drop_count(drop_count)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic idle2();
        tick();
        tick();
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rx_rdy_clr) break;
        end
        chk("cap_ack", rx_rdy_clr, 1);
        rx_rdy = 1'b0;
        if (accept) sb.push_back(b);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && m_valid; i++) begin
            chk("drain_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("drain_data", m_data, sb.pop_front());
            tick();
        end
        m_ready = 1'b0;
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_count", fifo_count, 0);
        chk("drain_m_data", m_data, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        m_ready = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
        idle2();
        chk("rst_clr", rx_rdy_clr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drops", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // Single byte: clear pulse one cycle after capture, byte visible immediately.
        enable = 1'b1; rx_data = 8'hA5; rx_rdy = 1'b1;
        tick();
        chk("a5_clr", rx_rdy_clr, 1);
        chk("a5_valid", m_valid, 1);
        chk("a5_data", m_data, 8'hA5);
        chk("a5_count", fifo_count, 1);
        rx_rdy = 1'b0;
        sb.push_back(8'hA5);
        tick();
        chk("a5_clr_low", rx_rdy_clr, 0);
        tick();
        chk("a5_clr_idle", rx_rdy_clr, 0);
        chk("a5_count2", fifo_count, 1);
        drain();

        // enable low leaves a held rx_rdy untouched.
        enable = 1'b0; rx_data = 8'h3C; rx_rdy = 1'b1;
        clr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_rdy_clr) clr_seen++;
        end
        chk("dis_clr", clr_seen, 0);
        chk("dis_count", fifo_count, 0);
        enable = 1'b1;
        tick();
        chk("en_clr", rx_rdy_clr, 1);
        chk("en_count", fifo_count, 1);
        rx_rdy = 1'b0;
        sb.push_back(8'h3C);
        idle2();
        chk("en_once", fifo_count, 1);
        drain();

        // Fill to DEPTH, ninth byte dropped.
        for (int i = 1; i <= DEPTH; i++) send(8'(i), 1'b1);
        idle2();
        chk("fill_count", fifo_count, DEPTH);
        chk("fill_overrun", overrun, 0);
        send(8'h09, 1'b0);
        chk("ovr_count", fifo_count, DEPTH);
        chk("ovr_flag", overrun, 1);
        chk("ovr_drops", drop_count, 1);
        idle2();
        drain();

        // Full FIFO, capture coinciding with a pop: no drop.
        for (int i = 0; i < DEPTH; i++) send(8'h11 + 8'(i), 1'b1);
        idle2();
        rx_data = 8'h19; rx_rdy = 1'b1; m_ready = 1'b1;
        chk("pp_head", m_data, sb[0]);
        void'(sb.pop_front());
        sb.push_back(8'h19);
        tick();
        m_ready = 1'b0; rx_rdy = 1'b0;
        chk("pp_clr", rx_rdy_clr, 1);
        chk("pp_count", fifo_count, DEPTH);
        chk("pp_drops", drop_count, 1);
        chk("pp_head2", m_data, 8'h12);
        idle2();
        drain();

        // Saturating drop counter, and a drop coinciding with overrun_clr.
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("oclr_flag", overrun, 0);
        chk("oclr_drops", drop_count, 0);
        for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i), 1'b1);
        for (int i = 0; i < 300; i++) send(8'hEE, 1'b0);
        idle2();
        chk("sat_drops", drop_count, 8'hFF);
        chk("sat_flag", overrun, 1);
        chk("sat_count", fifo_count, DEPTH);
        rx_data = 8'hEF; rx_rdy = 1'b1; overrun_clr = 1'b1;
        tick();
        rx_rdy = 1'b0; overrun_clr = 1'b0;
        chk("clrdrop_flag", overrun, 1);
        chk("clrdrop_drops", drop_count, 1);
        idle2();

        // Flush overrides a same-cycle capture and pop; FSM and drop state unaffected.
        rx_data = 8'hAA; rx_rdy = 1'b1; flush = 1'b1; m_ready = 1'b1;
        tick();
        rx_rdy = 1'b0; flush = 1'b0; m_ready = 1'b0;
        sb.delete();
        chk("fl_count", fifo_count, 0);
        chk("fl_valid", m_valid, 0);
        chk("fl_data", m_data, 8'h00);
        chk("fl_clr", rx_rdy_clr, 1);
        chk("fl_drops", drop_count, 1);
        chk("fl_flag", overrun, 1);
        idle2();
        send(8'h5A, 1'b1);
        chk("fl_head", m_data, 8'h5A);
        idle2();
        drain();

        // Reset mid-sequence with bytes queued, then capture a still-held rx_rdy.
        send(8'hC1, 1'b1);
        send(8'hC2, 1'b1);
        send(8'hC3, 1'b1);
        idle2();
        rx_data = 8'hC4; rx_rdy = 1'b1;
        tick();
        chk("mid_clr", rx_rdy_clr, 1);
        chk("mid_count", fifo_count, 4);
        rst_n = 1'b0;
        tick();
        chk("mrst_clr", rx_rdy_clr, 0);
        chk("mrst_valid", m_valid, 0);
        chk("mrst_data", m_data, 8'h00);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_drops", drop_count, 0);
        rst_n = 1'b1;
        sb.delete();
        tick();
        chk("post_clr", rx_rdy_clr, 1);
        chk("post_count", fifo_count, 1);
        chk("post_data", m_data, 8'hC4);
        rx_rdy = 1'b0;
        sb.push_back(8'hC4);
        idle2();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..256).
REQ-002 SHALL have port clk_50m  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port enable  input  1  1 = capture bytes from receiver; 0 = leave receiver untouched.
REQ-005 SHALL have port rx_rdy  input  1  receiver byte-ready flag (held high until cleared).
REQ-006 SHALL have port rx_data  input  8  receiver byte, valid while rx_rdy high.
REQ-007 SHALL have port rx_rdy_clr  output  1  one-cycle clear pulse to receiver.
REQ-008 SHALL have port m_data  output  8  FIFO head byte.
REQ-009 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port m_ready  input  1  consumer accepts head when m_valid high.
REQ-011 SHALL have port flush  input  1  synchronous FIFO discard.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-014 SHALL have port overrun_clr  input  1  clears overrun and drop_count.
REQ-015 SHALL have port drop_count  output  8  dropped bytes, saturating at 8'hFF.

Function
REQ-016 SHALL implement a three-state FSM: S_IDLE, S_CLEAR, S_HOLD.
REQ-017 In S_IDLE with enable=1 and rx_rdy=1, SHALL capture rx_data (push or drop) that cycle and go to S_CLEAR.
REQ-018 In S_IDLE with enable=0 or rx_rdy=0, SHALL remain in S_IDLE and not assert rx_rdy_clr.
REQ-019 rx_rdy_clr SHALL be a registered Moore output: high exactly during S_CLEAR, otherwise low.
REQ-020 S_CLEAR SHALL go unconditionally to S_HOLD; S_HOLD SHALL ignore rx_rdy and go unconditionally to S_IDLE.
REQ-021 A started capture sequence SHALL complete (S_CLEAR, S_HOLD) even if enable falls mid-sequence.
REQ-022 Each receiver byte SHALL be captured exactly once; minimum spacing between captures is 3 cycles.
REQ-023 Push SHALL be accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs the same cycle.
REQ-024 Push when full without same-cycle pop SHALL drop the byte, set overrun, and increment drop_count (saturating at 8'hFF).
REQ-025 Pop SHALL occur when m_valid=1 and m_ready=1; m_ready with m_valid=0 SHALL have no effect.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged and advance both pointers.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow.
REQ-028 Latency: byte captured in cycle N SHALL appear on m_data with m_valid=1 in cycle N+1 if FIFO was empty.
REQ-029 m_valid SHALL equal (fifo_count!=0); m_data SHALL show the head entry when m_valid=1 and 8'h00 when m_valid=0.
REQ-030 FIFO order SHALL be strictly first-in first-out.
REQ-031 flush=1 SHALL zero pointers and fifo_count next cycle, overriding same-cycle push and pop; a byte captured in that cycle is discarded, not counted as dropped.
REQ-032 flush SHALL NOT affect FSM state, overrun, or drop_count.
REQ-033 overrun_clr=1 SHALL clear overrun and drop_count next cycle; a same-cycle drop SHALL win (overrun=1, drop_count=1).

Reset
REQ-034 rst_n=0 at a clock edge SHALL force S_IDLE, pointers 0, fifo_count 0, m_valid 0, m_data 8'h00, rx_rdy_clr 0, overrun 0, drop_count 0.
REQ-035 Reset SHALL take priority over all other inputs, including mid-sequence (S_CLEAR or S_HOLD); FIFO contents are discarded.
REQ-036 After rst_n returns high, the block SHALL capture a still-asserted rx_rdy in the first S_IDLE cycle.

Verification
REQ-037 enable=1, rx_rdy rises with rx_data=8'hA5, m_ready=0 -> rx_rdy_clr high exactly one cycle, 1 cycle after capture; m_valid=1, m_data=8'hA5, fifo_count=1.
REQ-038 Push 8'h01..8'h08 (DEPTH=8), m_ready=0, then a 9th byte 8'h09 -> fifo_count=8, overrun=1, drop_count=1; drain yields 01..08 in order.
REQ-039 FIFO full, 9th byte captured in the same cycle as a pop -> no drop, fifo_count stays 8, last entry 8'h09.
REQ-040 rx_rdy held high with enable=0 for 20 cycles -> rx_rdy_clr stays 0, fifo_count=0; enable=1 -> single capture.
REQ-041 300 drops with no overrun_clr -> drop_count=8'hFF; overrun_clr coinciding with a drop -> overrun=1, drop_count=1.
REQ-042 rst_n=0 asserted while in S_CLEAR with 3 bytes queued -> next cycle all outputs at reset values, rx_rdy_clr=0.
